// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous data-memory port among CHANNELS
// requesters. Round-robin or fixed-priority grant, registered memory-side
// outputs, and a tag pipeline that routes read data back to its requester.
module mem_port_arbiter #(
    parameter int WIDTH        = 32,
    parameter int CHANNELS     = 2,
    parameter int READ_LATENCY = 1,
    parameter int FIXED_PRIO   = 0
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic [CHANNELS-1:0]       REQ,
    input  logic [CHANNELS-1:0]       WE,
    input  logic [CHANNELS*WIDTH-1:0] ADDR,
    input  logic [CHANNELS*WIDTH-1:0] WDATA,
    output logic [CHANNELS-1:0]       GNT,
    output logic [CHANNELS-1:0]       RVALID,
    output logic [WIDTH-1:0]          RDATA,
    output logic [WIDTH-1:0]          MEM_ADDR,
    output logic                      WRITE_MEM_EN,
    output logic [WIDTH-1:0]          WRITE_MEM_DATA,
    input  logic [WIDTH-1:0]          READ_MEM_DATA
);

    localparam int IDX_W = $clog2(CHANNELS);
    // One stage per cycle from grant edge to data-valid cycle.
    localparam int TAG_D = READ_LATENCY + 1;

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             gnt_any;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W:0]   cand;

    logic [WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0] sel_wdata;
    logic             sel_we;

    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic             mem_we_q, mem_we_d;

    logic             tag_vld_q [TAG_D];
    logic             tag_vld_d [TAG_D];
    logic [IDX_W-1:0] tag_idx_q [TAG_D];
    logic [IDX_W-1:0] tag_idx_d [TAG_D];

    // Pick the first requesting channel, searching from ptr (round-robin)
    // or from channel 0 (fixed priority); one extra bit on cand absorbs the wrap.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        GNT     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (FIXED_PRIO != 0) begin
                cand = (IDX_W+1)'(i);
            end else begin
                cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
                if (cand >= (IDX_W+1)'(CHANNELS)) begin
                    cand = cand - (IDX_W+1)'(CHANNELS);
                end
            end
            if (!gnt_any && REQ[cand[IDX_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[IDX_W-1:0];
            end
        end
        if (gnt_any) begin
            GNT[gnt_idx] = 1'b1;
        end
    end

    // Route the granted channel's address, data and direction to the port.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                sel_addr  = ADDR[i*WIDTH +: WIDTH];
                sel_wdata = WDATA[i*WIDTH +: WIDTH];
                sel_we    = WE[i];
            end
        end
    end

    // Next state: pointer advance, memory-side latch, tag shift.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any && FIXED_PRIO == 0) begin
            ptr_d = (gnt_idx == IDX_W'(CHANNELS-1)) ? '0 : gnt_idx + IDX_W'(1);
        end
        // Address and write data hold through idle cycles; enable drops.
        mem_addr_d  = gnt_any ? sel_addr  : mem_addr_q;
        mem_wdata_d = gnt_any ? sel_wdata : mem_wdata_q;
        mem_we_d    = gnt_any & sel_we;
        // Only reads carry a valid tag; writes and idle cycles push a bubble.
        tag_vld_d[0] = gnt_any & ~sel_we;
        tag_idx_d[0] = gnt_idx;
        for (int s = 1; s < TAG_D; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_idx_d[s] = tag_idx_q[s-1];
        end
    end

    // State registers; reset clears everything so in-flight reads are dropped.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ptr_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            for (int s = 0; s < TAG_D; s++) begin
                tag_vld_q[s] <= 1'b0;
                tag_idx_q[s] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            for (int s = 0; s < TAG_D; s++) begin
                tag_vld_q[s] <= tag_vld_d[s];
                tag_idx_q[s] <= tag_idx_d[s];
            end
        end
    end

    // Response steering: tag at the pipe end selects which RVALID bit fires.
    always_comb begin
        RVALID = '0;
        if (tag_vld_q[TAG_D-1]) begin
            RVALID[tag_idx_q[TAG_D-1]] = 1'b1;
        end
    end

    assign RDATA          = READ_MEM_DATA;
    assign MEM_ADDR       = mem_addr_q;
    assign WRITE_MEM_DATA = mem_wdata_q;
    assign WRITE_MEM_EN   = mem_we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a default 2-channel instance, a
// 4-channel round-robin instance with READ_LATENCY=3 and a 4-channel
// fixed-priority instance, all on a shared clock and reset.
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // 2-channel, latency 1, round-robin
    logic [1:0]  req2, we2, gnt2, rvalid2;
    logic [63:0] addr2, wdata2;
    logic [31:0] rdata2, maddr2, mwdata2, rmem2;
    logic        wen2;

    // 4-channel, latency 3, round-robin
    logic [3:0]   req_r4, we_r4, gnt_r4, rvalid_r4;
    logic [127:0] addr_r4, wdata_r4;
    logic [31:0]  rdata_r4, maddr_r4, mwdata_r4, rmem_r4;
    logic         wen_r4;

    // 4-channel, latency 1, fixed priority
    logic [3:0]   req_f4, we_f4, gnt_f4, rvalid_f4;
    logic [127:0] addr_f4, wdata_f4;
    logic [31:0]  rdata_f4, maddr_f4, mwdata_f4, rmem_f4;
    logic         wen_f4;

    mem_port_arbiter #(.WIDTH(32), .CHANNELS(2), .READ_LATENCY(1), .FIXED_PRIO(0)) u_dut2 (
        .CLK(clk), .RESET_N(rst_n), .REQ(req2), .WE(we2), .ADDR(addr2), .WDATA(wdata2),
        .GNT(gnt2), .RVALID(rvalid2), .RDATA(rdata2), .MEM_ADDR(maddr2),
        .WRITE_MEM_EN(wen2), .WRITE_MEM_DATA(mwdata2), .READ_MEM_DATA(rmem2)
    );

    mem_port_arbiter #(.WIDTH(32), .CHANNELS(4), .READ_LATENCY(3), .FIXED_PRIO(0)) u_rr4 (
        .CLK(clk), .RESET_N(rst_n), .REQ(req_r4), .WE(we_r4), .ADDR(addr_r4), .WDATA(wdata_r4),
        .GNT(gnt_r4), .RVALID(rvalid_r4), .RDATA(rdata_r4), .MEM_ADDR(maddr_r4),
        .WRITE_MEM_EN(wen_r4), .WRITE_MEM_DATA(mwdata_r4), .READ_MEM_DATA(rmem_r4)
    );

    mem_port_arbiter #(.WIDTH(32), .CHANNELS(4), .READ_LATENCY(1), .FIXED_PRIO(1)) u_fp4 (
        .CLK(clk), .RESET_N(rst_n), .REQ(req_f4), .WE(we_f4), .ADDR(addr_f4), .WDATA(wdata_f4),
        .GNT(gnt_f4), .RVALID(rvalid_f4), .RDATA(rdata_f4), .MEM_ADDR(maddr_f4),
        .WRITE_MEM_EN(wen_f4), .WRITE_MEM_DATA(mwdata_f4), .READ_MEM_DATA(rmem_f4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        req2 = '0; we2 = '0; addr2 = '0; wdata2 = '0; rmem2 = '0;
        req_r4 = '0; we_r4 = '0; addr_r4 = '0; wdata_r4 = '0; rmem_r4 = '0;
        req_f4 = '0; we_f4 = '0; addr_f4 = '0; wdata_f4 = '0; rmem_f4 = '0;

        // Reset state
        tick(); tick();
        chk("rst_maddr", maddr2, 0);
        chk("rst_wen", wen2, 0);
        chk("rst_wdata", mwdata2, 0);
        chk("rst_rvalid", rvalid2, 0);
        chk("rst_rvalid_r4", rvalid_r4, 0);

        // Mixed: ch0 writes 0x1234 to 0x10, then ch1 reads 0x10
        rst_n = 1'b1;
        req2 = 2'b01; we2 = 2'b01; addr2[31:0] = 32'h10; wdata2[31:0] = 32'h1234;
        #1 chk("mix_gnt_w", gnt2, 2'b01);
        tick();
        chk("mix_wen_t1", wen2, 1);
        chk("mix_maddr_t1", maddr2, 32'h10);
        chk("mix_wdata_t1", mwdata2, 32'h1234);
        req2 = 2'b10; we2 = 2'b00; addr2[63:32] = 32'h10;
        #1 chk("mix_gnt_r", gnt2, 2'b10);
        chk("mix_rvalid_t1", rvalid2, 0);
        tick();
        req2 = 2'b00;
        chk("mix_wen_t2", wen2, 0);
        chk("mix_maddr_t2", maddr2, 32'h10);
        chk("mix_rvalid_t2", rvalid2, 0);
        tick();
        rmem2 = 32'h1234;
        #1 chk("mix_rvalid_t3", rvalid2, 2'b10);
        chk("mix_rdata_t3", rdata2, 32'h1234);
        chk("mix_wen_t3", wen2, 0);
        tick();
        chk("mix_rvalid_t4", rvalid2, 0);

        // Single read: ch1 reads 0x40
        req2 = 2'b10; we2 = 2'b00; addr2[63:32] = 32'h40;
        #1 chk("rd_gnt", gnt2, 2'b10);
        tick();
        req2 = 2'b00;
        chk("rd_maddr", maddr2, 32'h40);
        chk("rd_wen", wen2, 0);
        chk("rd_rvalid_t1", rvalid2, 0);
        #1 chk("rd_gnt_idle", gnt2, 2'b00);
        tick();
        rmem2 = 32'hDEAD_BEEF;
        #1 chk("rd_rvalid_t2", rvalid2, 2'b10);
        chk("rd_rdata_t2", rdata2, 32'hDEAD_BEEF);
        tick();

        // Write from ch0 moves ptr to 1, then reset mid-cycle with REQ=11
        req2 = 2'b01; we2 = 2'b01; addr2[31:0] = 32'h80; wdata2[31:0] = 32'hCAFE;
        #1 chk("pre_rst_gnt", gnt2, 2'b01);
        tick();
        chk("pre_rst_wen", wen2, 1);
        chk("pre_rst_maddr", maddr2, 32'h80);
        req2 = 2'b11; we2 = 2'b00;
        #3 rst_n = 1'b0;
        #1 chk("async_maddr", maddr2, 0);
        chk("async_wen", wen2, 0);
        chk("async_wdata", mwdata2, 0);
        chk("async_rvalid", rvalid2, 0);
        tick(); tick();
        chk("in_rst_maddr", maddr2, 0);
        chk("in_rst_rvalid", rvalid2, 0);
        rst_n = 1'b1;
        addr2[31:0] = 32'h20; addr2[63:32] = 32'h24;
        #1 chk("post_rst_gnt0", gnt2, 2'b01);
        tick();
        chk("post_rst_maddr0", maddr2, 32'h20);
        chk("post_rst_wen", wen2, 0);
        #1 chk("post_rst_gnt1", gnt2, 2'b10);
        tick();
        chk("post_rst_maddr1", maddr2, 32'h24);
        req2 = 2'b00;

        // Round-robin, 4 channels all requesting for 8 cycles, then drain
        for (int i = 0; i < 12; i++) begin
            req_r4 = (i < 8) ? 4'hF : 4'h0;
            rmem_r4 = 32'h5000 + i;
            #1;
            chk($sformatf("rr4_gnt_%0d", i), gnt_r4, (i < 8) ? (128'(1) << (i % 4)) : 128'(0));
            chk($sformatf("rr4_rvalid_%0d", i), rvalid_r4,
                (i < 4) ? 128'(0) : (128'(1) << ((i - 4) % 4)));
            tick();
        end
        chk("rr4_rvalid_drained", rvalid_r4, 0);
        chk("rr4_rdata_pass", rdata_r4, 32'h5000 + 11);

        // Reset with reads in flight (latency 3): no late responses
        req_r4 = 4'b0001;
        #1 chk("flight_gnt0", gnt_r4, 4'b0001);
        tick();
        req_r4 = 4'b0010;
        #1 chk("flight_gnt1", gnt_r4, 4'b0010);
        tick();
        req_r4 = 4'b0000;
        rst_n = 1'b0;
        #1 chk("flight_rvalid_rst", rvalid_r4, 0);
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("flight_rvalid_%0d", j), rvalid_r4, 0);
            tick();
        end

        // Fixed priority: ch1 always beats ch3
        addr_f4[63:32] = 32'h111; addr_f4[127:96] = 32'h333; addr_f4[31:0] = 32'h100;
        req_f4 = 4'b1010; we_f4 = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("fp_gnt_%0d", k), gnt_f4, 4'b0010);
            tick();
            chk($sformatf("fp_maddr_%0d", k), maddr_f4, 32'h111);
        end
        req_f4 = 4'b1000;
        #1 chk("fp_single_gnt", gnt_f4, 4'b1000);
        tick();
        chk("fp_single_maddr", maddr_f4, 32'h333);
        chk("fp_rvalid_ch1", rvalid_f4, 4'b0010);
        req_f4 = 4'b1011;
        #1 chk("fp_low_gnt", gnt_f4, 4'b0001);
        tick();
        req_f4 = 4'b0000;
        chk("fp_rvalid_ch3", rvalid_f4, 4'b1000);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
